// File: rtl/sched_pkg.sv
// Shared types and helpers for the fixed-priority scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sched_pkg;

    // Scheduler FSM: waiting for a request, or holding a grant.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Widest grant vector onehot() can build; callers truncate to their N.
    localparam int ONEHOT_W = 64;

    // One-hot vector with only bit idx set.
    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
        onehot = ONEHOT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Highest-set-bit priority encoder with a found flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module prio_enc #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]  i_vec,
    output logic [OUT_WIDTH-1:0] o_idx,
    output logic                 o_found
);

    // Scan upward so the last (highest) set bit overwrites any lower one.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (i_vec[i]) begin
                o_idx   = OUT_WIDTH'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_sched.sv
// Fixed-priority scheduler: highest eligible requester owns the resource until done/drop/hold budget.
// Latency: grant registered one edge after request is sampled in IDLE; release one edge after done/drop.
// Backpressure: losers simply keep requesting; a timed-out requester is skipped for one arbitration.
module prio_sched
    import sched_pkg::*;
#(
    parameter int N        = 8,
    parameter int ID_W     = $clog2(N),
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            timeout
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     w_gnt_nxt;
    logic [ID_W-1:0]  r_gnt_id;
    logic [ID_W-1:0]  w_gnt_id_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic [N-1:0]     r_mask;
    logic [N-1:0]     w_mask_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [N-1:0]     w_elig;
    logic [ID_W-1:0]  w_win_id;
    logic             w_win_found;
    logic             w_release;
    logic             w_expire;

    // Requesters that were revoked last time sit out one arbitration.
    assign w_elig = req & ~r_mask;

    prio_enc #(
        .IN_WIDTH  (N),
        .OUT_WIDTH (ID_W)
    ) u_prio_enc (
        .i_vec   (w_elig),
        .o_idx   (w_win_id),
        .o_found (w_win_found)
    );

    // A holder leaves voluntarily on done or by dropping its own request.
    assign w_release = done | ~req[r_gnt_id];
    assign w_expire  = (r_cnt == CNT_W'(MAX_HOLD - 1));

    // Next-state and next-output decode; release wins over expiry on the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_mask_nxt    = r_mask;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_state_nxt  = BUSY;
                    w_gnt_id_nxt = w_win_id;
                    w_gnt_nxt    = N'(onehot(32'(w_win_id)));
                    w_busy_nxt   = 1'b1;
                    w_cnt_nxt    = '0;
                    w_mask_nxt   = '0;
                end else if (|req) begin
                    // Only masked requesters are asking: lift the mask, grant next cycle.
                    w_mask_nxt = '0;
                end
            end
            BUSY: begin
                if (w_release || w_expire) begin
                    w_state_nxt  = IDLE;
                    w_gnt_nxt    = '0;
                    w_gnt_id_nxt = '0;
                    w_busy_nxt   = 1'b0;
                    w_cnt_nxt    = '0;
                    if (!w_release) begin
                        w_timeout_nxt        = 1'b1;
                        w_mask_nxt[r_gnt_id] = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_gnt_nxt    = '0;
                w_gnt_id_nxt = '0;
                w_busy_nxt   = 1'b0;
                w_cnt_nxt    = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, hold counter and skip mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_mask    <= '0;
            r_cnt     <= '0;
        end else begin
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_mask    <= w_mask_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_prio_sched.sv
// Directed bench for prio_sched with N=8, MAX_HOLD=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Each scenario task checks its own expectations inline.
module tb_prio_sched;

    localparam int N        = 8;
    localparam int ID_W     = 3;
    localparam int MAX_HOLD = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            busy;
    logic            timeout;

    int n_pass;
    int n_total;

    prio_sched #(
        .N        (N),
        .ID_W     (ID_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0)
                $display("FAIL reset_hold[%0d]: gnt=%h busy=%b timeout=%b, want 00/0/0", i, gnt, busy, timeout);
            else n_pass++;
        end
        rst = 1'b0;
        tick();
        n_total++;
        if (gnt !== 8'h80 || gnt_id !== 3'd7 || busy !== 1'b1)
            $display("FAIL reset_first_grant: gnt=%h id=%0d busy=%b, want 80/7/1", gnt, gnt_id, busy);
        else n_pass++;
        req = 8'h00;
        tick();
        n_total++;
        if (gnt !== 8'h00 || busy !== 1'b0 || gnt_id !== 3'd0)
            $display("FAIL reset_drop_release: gnt=%h busy=%b id=%0d, want 00/0/0", gnt, busy, gnt_id);
        else n_pass++;
        tick();
    endtask

    task automatic test_priority();
        req = 8'b0010_0110;
        tick();
        n_total++;
        if (gnt_id !== 3'd5 || gnt !== 8'h20)
            $display("FAIL prio_first: id=%0d gnt=%h, want 5/20", gnt_id, gnt);
        else n_pass++;
        done = 1'b1;
        req  = 8'b0000_0110;
        tick();
        done = 1'b0;
        n_total++;
        if (gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0)
            $display("FAIL prio_gap: gnt=%h busy=%b timeout=%b, want 00/0/0", gnt, busy, timeout);
        else n_pass++;
        tick();
        n_total++;
        if (gnt_id !== 3'd2 || gnt !== 8'h04)
            $display("FAIL prio_second: id=%0d gnt=%h, want 2/04", gnt_id, gnt);
        else n_pass++;
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_drop();
        req = 8'h08;
        tick();
        n_total++;
        if (gnt_id !== 3'd3 || gnt !== 8'h08)
            $display("FAIL drop_grant: id=%0d gnt=%h, want 3/08", gnt_id, gnt);
        else n_pass++;
        // done while idle must not matter; dropped request releases
        req = 8'h00;
        tick();
        n_total++;
        if (gnt !== 8'h00 || timeout !== 1'b0 || busy !== 1'b0)
            $display("FAIL drop_release: gnt=%h timeout=%b busy=%b, want 00/0/0", gnt, timeout, busy);
        else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_total++;
        if (gnt !== 8'h00 || busy !== 1'b0)
            $display("FAIL idle_done_ignored: gnt=%h busy=%b, want 00/0", gnt, busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int hi;
        req = 8'h80;
        tick();
        hi = (gnt === 8'h80) ? 1 : 0;
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            tick();
            if (gnt === 8'h80 && timeout === 1'b0) hi++;
        end
        n_total++;
        if (hi !== MAX_HOLD)
            $display("FAIL timeout_hold_len: high cycles=%0d, want %0d", hi, MAX_HOLD);
        else n_pass++;
        tick();
        n_total++;
        if (gnt !== 8'h00 || timeout !== 1'b1 || busy !== 1'b0)
            $display("FAIL timeout_pulse: gnt=%h timeout=%b busy=%b, want 00/1/0", gnt, timeout, busy);
        else n_pass++;
        // Only the masked requester asks: one idle cycle clears the mask.
        tick();
        n_total++;
        if (gnt !== 8'h00 || timeout !== 1'b0)
            $display("FAIL timeout_mask_clear: gnt=%h timeout=%b, want 00/0", gnt, timeout);
        else n_pass++;
        tick();
        n_total++;
        if (gnt_id !== 3'd7 || gnt !== 8'h80)
            $display("FAIL timeout_regrant: id=%0d gnt=%h, want 7/80", gnt_id, gnt);
        else n_pass++;
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_timeout_skip();
        req = 8'h80;
        tick();
        // Bit 0 arriving mid-grant must not disturb the holder.
        req = 8'h81;
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        n_total++;
        if (gnt !== 8'h80)
            $display("FAIL skip_hold: gnt=%h, want 80", gnt);
        else n_pass++;
        tick();
        n_total++;
        if (timeout !== 1'b1 || gnt !== 8'h00)
            $display("FAIL skip_timeout: timeout=%b gnt=%h, want 1/00", timeout, gnt);
        else n_pass++;
        tick();
        n_total++;
        if (gnt_id !== 3'd0 || gnt !== 8'h01 || timeout !== 1'b0)
            $display("FAIL skip_next: id=%0d gnt=%h timeout=%b, want 0/01/0", gnt_id, gnt, timeout);
        else n_pass++;
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_collision();
        req = 8'h80;
        tick();
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_total++;
        if (gnt !== 8'h00 || timeout !== 1'b0)
            $display("FAIL collision_release: gnt=%h timeout=%b, want 00/0", gnt, timeout);
        else n_pass++;
        tick();
        n_total++;
        if (gnt !== 8'h80 || gnt_id !== 3'd7)
            $display("FAIL collision_not_masked: gnt=%h id=%0d, want 80/7", gnt, gnt_id);
        else n_pass++;
        req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        int hi;
        req = 8'h40;
        tick();
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (gnt !== 8'h00 || gnt_id !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0)
            $display("FAIL midrst_clear: gnt=%h id=%0d busy=%b timeout=%b, want all 0", gnt, gnt_id, busy, timeout);
        else n_pass++;
        tick();
        hi = (gnt === 8'h40) ? 1 : 0;
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            tick();
            if (gnt === 8'h40 && timeout === 1'b0) hi++;
        end
        n_total++;
        if (hi !== MAX_HOLD)
            $display("FAIL midrst_counter_restart: high cycles=%0d, want %0d", hi, MAX_HOLD);
        else n_pass++;
        tick();
        n_total++;
        if (timeout !== 1'b1 || gnt !== 8'h00)
            $display("FAIL midrst_timeout: timeout=%b gnt=%h, want 1/00", timeout, gnt);
        else n_pass++;
        req = 8'h00;
        tick();
        n_total++;
        if (timeout !== 1'b0)
            $display("FAIL midrst_pulse_width: timeout=%b, want 0", timeout);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        req     = '0;
        done    = 1'b0;
        #1;
        test_reset();
        test_priority();
        test_drop();
        test_timeout();
        test_timeout_skip();
        test_collision();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
